// File: rtl/rst_pkg.sv
// rst_pkg: shared default sizes and width helpers for the rename status table.
package rst_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int TAG_W_DEF    = 6;
    localparam int NUM_CKPT_DEF = 4;

    // Ceiling log2, never below 1 so a tiny structure still gets an index bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // One table entry is a pending bit plus the tag it waits on.
    function automatic int entry_w(input int tag_w);
        return tag_w + 1;
    endfunction

endpackage

// File: rtl/rst_table_if.sv
// rst_table_if: read, rename-write, CDB, lookup and checkpoint signals of rst_table.
interface rst_table_if
    import rst_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int NUM_CKPT = NUM_CKPT_DEF
);
    localparam int AW = clog2(NUM_REGS);
    localparam int CW = clog2(NUM_CKPT);

    logic [NUM_RD*AW-1:0]    rd_addr;
    logic [NUM_RD-1:0]       rd_valid;
    logic [NUM_RD*TAG_W-1:0] rd_tag;
    logic [NUM_WR*AW-1:0]    wr_addr;
    logic [NUM_WR*TAG_W-1:0] wr_tag;
    logic [NUM_WR-1:0]       wr_en;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [TAG_W-1:0]        lookup_tag;
    logic                    lookup_found;
    logic [AW-1:0]           lookup_addr;
    logic                    ckpt_save;
    logic [CW-1:0]           ckpt_id;
    logic                    ckpt_restore;
    logic [CW-1:0]           restore_id;
    logic                    ckpt_release;
    logic                    flush;
    logic                    ckpt_full;
    logic                    ckpt_empty;
    logic [CW:0]             ckpt_count;

    modport master (
        output rd_addr, wr_addr, wr_tag, wr_en, cdb_valid, cdb_tag, lookup_tag,
               ckpt_save, ckpt_restore, restore_id, ckpt_release, flush,
        input  rd_valid, rd_tag, lookup_found, lookup_addr, ckpt_id,
               ckpt_full, ckpt_empty, ckpt_count
    );

    modport slave (
        input  rd_addr, wr_addr, wr_tag, wr_en, cdb_valid, cdb_tag, lookup_tag,
               ckpt_save, ckpt_restore, restore_id, ckpt_release, flush,
        output rd_valid, rd_tag, lookup_found, lookup_addr, ckpt_id,
               ckpt_full, ckpt_empty, ckpt_count
    );

endinterface

// File: rtl/rst_ckpt_fifo.sv
// rst_ckpt_fifo: circular FIFO of table snapshots with head/tail/count and id-range check.
module rst_ckpt_fifo
    import rst_pkg::*;
#(
    parameter int NUM_CKPT = NUM_CKPT_DEF,
    parameter int CW       = clog2(NUM_CKPT),
    parameter int TBL_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             save_req,
    input  logic             release_req,
    input  logic             restore_req,
    input  logic [CW-1:0]    restore_id,
    input  logic [TBL_W-1:0] save_data,
    output logic [TBL_W-1:0] restore_data,
    output logic             restore_ok,
    output logic [CW-1:0]    ckpt_id,
    output logic [CW:0]      ckpt_count,
    output logic             ckpt_full,
    output logic             ckpt_empty
);
    localparam int            CNTW  = CW + 1;
    localparam logic [CW-1:0] LAST  = CW'(NUM_CKPT - 1);
    localparam logic [CW:0]   DEPTH = CNTW'(NUM_CKPT);

    logic [TBL_W-1:0] snap [NUM_CKPT];
    logic [CW-1:0]    head_q;
    logic [CW-1:0]    tail_q;
    logic [CW:0]      count_q;
    logic [CW:0]      offset;
    logic             save_ok;
    logic             release_ok;

    function automatic logic [CW-1:0] inc_ptr(input logic [CW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Age of restore_id relative to head, wrapped; the id is live when that age is below count.
    always_comb begin
        if (restore_id >= head_q) offset = {1'b0, restore_id} - {1'b0, head_q};
        else                      offset = {1'b0, restore_id} + DEPTH - {1'b0, head_q};
    end

    assign restore_ok   = restore_req && !flush && (restore_id <= LAST) && (offset < count_q);
    assign release_ok   = release_req && !flush && !restore_ok && (count_q != '0);
    assign save_ok      = save_req && !flush && !restore_ok && ((count_q != DEPTH) || release_ok);
    assign restore_data = snap[restore_id];
    assign ckpt_id      = tail_q;
    assign ckpt_count   = count_q;
    assign ckpt_full    = (count_q == DEPTH);
    assign ckpt_empty   = (count_q == '0);

    // Pointer and occupancy update; restore trims the FIFO back to the restored slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (restore_ok) begin
            tail_q  <= restore_id;
            count_q <= offset;
        end else begin
            if (save_ok)    tail_q <= inc_ptr(tail_q);
            if (release_ok) head_q <= inc_ptr(head_q);
            if (save_ok && !release_ok)      count_q <= count_q + 1'b1;
            else if (!save_ok && release_ok) count_q <= count_q - 1'b1;
        end
    end

    // Snapshot storage is never cleared; freed slots simply keep stale data.
    always_ff @(posedge clk) begin
        if (reset_n && save_ok) snap[tail_q] <= save_data;
    end

endmodule

// File: rtl/rst_table.sv
// rst_table: register status table with rename writes, CDB wakeup, reverse lookup and checkpoints.
module rst_table
    import rst_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int NUM_CKPT = NUM_CKPT_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    rst_table_if.slave bus
);
    localparam int AW    = clog2(NUM_REGS);
    localparam int CW    = clog2(NUM_CKPT);
    localparam int EW    = entry_w(TAG_W);
    localparam int TBL_W = NUM_REGS * EW;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           tbl_q    [NUM_REGS];
    entry_t           next_tbl [NUM_REGS];
    entry_t           restored [NUM_REGS];
    logic [TBL_W-1:0] save_flat;
    logic [TBL_W-1:0] restore_flat;
    logic             restore_ok;

    // Next live table: CDB clears first, then rename writes in port order so writes win.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            next_tbl[i] = tbl_q[i];
            if (bus.cdb_valid && tbl_q[i].valid && (tbl_q[i].tag == bus.cdb_tag))
                next_tbl[i].valid = 1'b0;
        end
        for (int p = 0; p < NUM_WR; p++) begin
            if (bus.wr_en[p])
                next_tbl[bus.wr_addr[p*AW +: AW]] = '{valid: 1'b1, tag: bus.wr_tag[p*TAG_W +: TAG_W]};
        end
    end

    // Snapshot being restored, with the same-cycle CDB broadcast applied on top of it.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            entry_t e;
            e = restore_flat[i*EW +: EW];
            if (bus.cdb_valid && e.valid && (e.tag == bus.cdb_tag))
                e.valid = 1'b0;
            restored[i] = e;
        end
    end

    // A save captures the table as it will look after this edge.
    always_comb begin
        save_flat = '0;
        for (int i = 0; i < NUM_REGS; i++)
            save_flat[i*EW +: EW] = next_tbl[i];
    end

    // Live table: flush drops every pending bit, restore reloads, otherwise normal update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) tbl_q[i] <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < NUM_REGS; i++) tbl_q[i].valid <= 1'b0;
        end else if (restore_ok) begin
            for (int i = 0; i < NUM_REGS; i++) tbl_q[i] <= restored[i];
        end else begin
            for (int i = 0; i < NUM_REGS; i++) tbl_q[i] <= next_tbl[i];
        end
    end

    // Read ports see registered state only; a write in flight is not bypassed.
    always_comb begin
        bus.rd_valid = '0;
        bus.rd_tag   = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            bus.rd_valid[r]              = tbl_q[bus.rd_addr[r*AW +: AW]].valid;
            bus.rd_tag[r*TAG_W +: TAG_W] = tbl_q[bus.rd_addr[r*AW +: AW]].tag;
        end
    end

    // Reverse search over pending entries; later indices overwrite so the highest match wins.
    always_comb begin
        bus.lookup_found = 1'b0;
        bus.lookup_addr  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (tbl_q[i].valid && (tbl_q[i].tag == bus.lookup_tag)) begin
                bus.lookup_found = 1'b1;
                bus.lookup_addr  = AW'(i);
            end
        end
    end

    rst_ckpt_fifo #(
        .NUM_CKPT (NUM_CKPT),
        .CW       (CW),
        .TBL_W    (TBL_W)
    ) u_ckpt (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (bus.flush),
        .save_req     (bus.ckpt_save),
        .release_req  (bus.ckpt_release),
        .restore_req  (bus.ckpt_restore),
        .restore_id   (bus.restore_id),
        .save_data    (save_flat),
        .restore_data (restore_flat),
        .restore_ok   (restore_ok),
        .ckpt_id      (bus.ckpt_id),
        .ckpt_count   (bus.ckpt_count),
        .ckpt_full    (bus.ckpt_full),
        .ckpt_empty   (bus.ckpt_empty)
    );

endmodule

// File: tb/tb_rst_table.sv
// tb_rst_table: table-driven cycles with a result scoreboard, plus reset corner sequences.
module tb_rst_table;
    import rst_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rst_table_if bus ();

    rst_table dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        string      name;
        logic [1:0] we;
        logic [4:0] wa0, wa1;
        logic [5:0] wt0, wt1;
        logic       cdb;
        logic [5:0] ct;
        logic       sv, rl, rs;
        logic [1:0] rid;
        logic       fl;
        logic [4:0] ra;
        logic [5:0] lt;
        logic       pv;
        logic [5:0] pt;
        logic       ev;
        logic [5:0] et;
        logic       ef;
        logic [4:0] ea;
        logic [2:0] ec;
        logic [1:0] eid;
    } vec_t;

    typedef struct {
        string      name;
        logic       ev;
        logic [5:0] et;
        logic       ef;
        logic [4:0] ea;
        logic [2:0] ec;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t make_vec(input string n, input int we, input int wa0, input int wt0,
                                      input int wa1, input int wt1, input int cdb, input int ct,
                                      input int sv, input int rl, input int rs, input int rid,
                                      input int fl, input int ra, input int lt, input int pv,
                                      input int pt, input int ev, input int et, input int ef,
                                      input int ea, input int ec, input int eid);
        vec_t v;
        v.name = n;   v.we = 2'(we);   v.wa0 = 5'(wa0); v.wt0 = 6'(wt0);
        v.wa1 = 5'(wa1); v.wt1 = 6'(wt1); v.cdb = 1'(cdb); v.ct = 6'(ct);
        v.sv = 1'(sv); v.rl = 1'(rl);  v.rs = 1'(rs);   v.rid = 2'(rid);
        v.fl = 1'(fl); v.ra = 5'(ra);  v.lt = 6'(lt);   v.pv = 1'(pv);
        v.pt = 6'(pt); v.ev = 1'(ev);  v.et = 6'(et);   v.ef = 1'(ef);
        v.ea = 5'(ea); v.ec = 3'(ec);  v.eid = 2'(eid);
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.wr_en        = '0;
        bus.wr_addr      = '0;
        bus.wr_tag       = '0;
        bus.cdb_valid    = 1'b0;
        bus.cdb_tag      = '0;
        bus.ckpt_save    = 1'b0;
        bus.ckpt_release = 1'b0;
        bus.ckpt_restore = 1'b0;
        bus.restore_id   = '0;
        bus.flush        = 1'b0;
    endtask

    task automatic check_state(input string name, input logic ev, input logic [5:0] et,
                               input logic ef, input logic [4:0] ea, input logic [2:0] ec);
        check_output($sformatf("%s.rd_valid", name), 32'(bus.rd_valid), 32'({ev, ev}));
        check_output($sformatf("%s.rd_tag", name), 32'(bus.rd_tag), 32'({et, et}));
        check_output($sformatf("%s.found", name), 32'(bus.lookup_found), 32'(ef));
        check_output($sformatf("%s.laddr", name), 32'(bus.lookup_addr), 32'(ea));
        check_output($sformatf("%s.count", name), 32'(bus.ckpt_count), 32'(ec));
        check_output($sformatf("%s.full", name), 32'(bus.ckpt_full), 32'(ec == 3'd4));
        check_output($sformatf("%s.empty", name), 32'(bus.ckpt_empty), 32'(ec == 3'd0));
    endtask

    task automatic apply_stimulus(input vec_t v);
        exp_t e;
        bus.wr_en        = v.we;
        bus.wr_addr      = {v.wa1, v.wa0};
        bus.wr_tag       = {v.wt1, v.wt0};
        bus.cdb_valid    = v.cdb;
        bus.cdb_tag      = v.ct;
        bus.ckpt_save    = v.sv;
        bus.ckpt_release = v.rl;
        bus.ckpt_restore = v.rs;
        bus.restore_id   = v.rid;
        bus.flush        = v.fl;
        bus.rd_addr      = {v.ra, v.ra};
        bus.lookup_tag   = v.lt;
        #1;
        check_output($sformatf("%s.pre_valid", v.name), 32'(bus.rd_valid), 32'({v.pv, v.pv}));
        check_output($sformatf("%s.pre_tag", v.name), 32'(bus.rd_tag), 32'({v.pt, v.pt}));
        check_output($sformatf("%s.ckpt_id", v.name), 32'(bus.ckpt_id), 32'(v.eid));
        e.name = v.name; e.ev = v.ev; e.et = v.et; e.ef = v.ef; e.ea = v.ea; e.ec = v.ec;
        sb.push_back(e);
        @(posedge clk);
        #1;
        drive_idle();
        e = sb.pop_front();
        check_state(e.name, e.ev, e.et, e.ef, e.ea, e.ec);
    endtask

    initial begin
        //                 name               we wa0 wt0   wa1 wt1   cdb ct    sv rl rs rid fl ra lt    pv pt    ev et    ef ea ec eid
        vecs.push_back(make_vec("dual_write",      3, 3, 'h11, 3, 'h22, 0, 0,    0, 0, 0, 0, 0, 3, 'h22, 0, 0,    1, 'h22, 1, 3, 0, 0));
        vecs.push_back(make_vec("set_r5",          1, 5, 'h07, 0, 0,    0, 0,    0, 0, 0, 0, 0, 5, 'h07, 0, 0,    1, 'h07, 1, 5, 0, 0));
        vecs.push_back(make_vec("wr_beats_cdb",    1, 5, 'h09, 0, 0,    1, 'h07, 0, 0, 0, 0, 0, 5, 'h09, 1, 'h07, 1, 'h09, 1, 5, 0, 0));
        vecs.push_back(make_vec("rearm_r5",        1, 5, 'h07, 0, 0,    0, 0,    0, 0, 0, 0, 0, 5, 'h07, 1, 'h09, 1, 'h07, 1, 5, 0, 0));
        vecs.push_back(make_vec("cdb_clear",       0, 0, 0,    0, 0,    1, 'h07, 0, 0, 0, 0, 0, 5, 'h07, 1, 'h07, 0, 'h07, 0, 0, 0, 0));
        vecs.push_back(make_vec("multi_match",     3, 2, 'h22, 9, 'h22, 0, 0,    0, 0, 0, 0, 0, 9, 'h22, 0, 0,    1, 'h22, 1, 9, 0, 0));
        vecs.push_back(make_vec("cdb_multi",       0, 0, 0,    0, 0,    1, 'h22, 0, 0, 0, 0, 0, 3, 'h22, 1, 'h22, 0, 'h22, 0, 0, 0, 0));
        vecs.push_back(make_vec("save0",           0, 0, 0,    0, 0,    0, 0,    1, 0, 0, 0, 0, 3, 0,    0, 'h22, 0, 'h22, 0, 0, 1, 0));
        vecs.push_back(make_vec("save1",           0, 0, 0,    0, 0,    0, 0,    1, 0, 0, 0, 0, 3, 0,    0, 'h22, 0, 'h22, 0, 0, 2, 1));
        vecs.push_back(make_vec("save2",           0, 0, 0,    0, 0,    0, 0,    1, 0, 0, 0, 0, 3, 0,    0, 'h22, 0, 'h22, 0, 0, 3, 2));
        vecs.push_back(make_vec("save3",           0, 0, 0,    0, 0,    0, 0,    1, 0, 0, 0, 0, 3, 0,    0, 'h22, 0, 'h22, 0, 0, 4, 3));
        vecs.push_back(make_vec("save_when_full",  0, 0, 0,    0, 0,    0, 0,    1, 0, 0, 0, 0, 3, 0,    0, 'h22, 0, 'h22, 0, 0, 4, 0));
        vecs.push_back(make_vec("save_rel_full",   0, 0, 0,    0, 0,    0, 0,    1, 1, 0, 0, 0, 3, 0,    0, 'h22, 0, 'h22, 0, 0, 4, 0));
        vecs.push_back(make_vec("rel_a",           0, 0, 0,    0, 0,    0, 0,    0, 1, 0, 0, 0, 3, 0,    0, 'h22, 0, 'h22, 0, 0, 3, 1));
        vecs.push_back(make_vec("rel_b",           0, 0, 0,    0, 0,    0, 0,    0, 1, 0, 0, 0, 3, 0,    0, 'h22, 0, 'h22, 0, 0, 2, 1));
        vecs.push_back(make_vec("rel_c",           0, 0, 0,    0, 0,    0, 0,    0, 1, 0, 0, 0, 3, 0,    0, 'h22, 0, 'h22, 0, 0, 1, 1));
        vecs.push_back(make_vec("rel_d",           0, 0, 0,    0, 0,    0, 0,    0, 1, 0, 0, 0, 3, 0,    0, 'h22, 0, 'h22, 0, 0, 0, 1));
        vecs.push_back(make_vec("rel_empty",       0, 0, 0,    0, 0,    0, 0,    0, 1, 0, 0, 0, 3, 0,    0, 'h22, 0, 'h22, 0, 0, 0, 1));
        vecs.push_back(make_vec("set_r6",          1, 6, 'h15, 0, 0,    0, 0,    0, 0, 0, 0, 0, 6, 'h15, 0, 0,    1, 'h15, 1, 6, 0, 1));
        vecs.push_back(make_vec("flush_wr",        1, 4, 'h2a, 0, 0,    0, 0,    1, 0, 0, 0, 1, 6, 'h15, 1, 'h15, 0, 'h15, 0, 0, 0, 1));
        vecs.push_back(make_vec("after_flush",     0, 0, 0,    0, 0,    0, 0,    0, 0, 0, 0, 0, 4, 'h2a, 0, 0,    0, 0,    0, 0, 0, 0));
        vecs.push_back(make_vec("r1_set",          1, 1, 'h01, 0, 0,    0, 0,    0, 0, 0, 0, 0, 1, 'h01, 0, 0,    1, 'h01, 1, 1, 0, 0));
        vecs.push_back(make_vec("save_a",          0, 0, 0,    0, 0,    0, 0,    1, 0, 0, 0, 0, 1, 'h01, 1, 'h01, 1, 'h01, 1, 1, 1, 0));
        vecs.push_back(make_vec("r1_retag",        1, 1, 'h02, 0, 0,    0, 0,    0, 0, 0, 0, 0, 1, 'h02, 1, 'h01, 1, 'h02, 1, 1, 1, 1));
        vecs.push_back(make_vec("save_b",          0, 0, 0,    0, 0,    0, 0,    1, 0, 0, 0, 0, 1, 'h02, 1, 'h02, 1, 'h02, 1, 1, 2, 1));
        vecs.push_back(make_vec("restore_at_tail", 1, 1, 'h03, 0, 0,    0, 0,    0, 0, 1, 2, 0, 1, 'h03, 1, 'h02, 1, 'h03, 1, 1, 2, 2));
        vecs.push_back(make_vec("restore_0_cdb",   1, 1, 'h3f, 0, 0,    1, 'h01, 1, 1, 1, 0, 0, 1, 'h01, 1, 'h03, 0, 'h01, 0, 0, 0, 2));
        vecs.push_back(make_vec("save_c",          0, 0, 0,    0, 0,    0, 0,    1, 0, 0, 0, 0, 7, 'h30, 0, 0,    0, 0,    0, 0, 1, 0));
        vecs.push_back(make_vec("wr_save",         1, 7, 'h30, 0, 0,    0, 0,    1, 0, 0, 0, 0, 7, 'h30, 0, 0,    1, 'h30, 1, 7, 2, 1));
        vecs.push_back(make_vec("rel_oldest",      0, 0, 0,    0, 0,    0, 0,    0, 1, 0, 0, 0, 7, 'h30, 1, 'h30, 1, 'h30, 1, 7, 1, 2));
        vecs.push_back(make_vec("r7_retag",        1, 7, 'h31, 0, 0,    0, 0,    0, 0, 0, 0, 0, 7, 'h31, 1, 'h30, 1, 'h31, 1, 7, 1, 2));
        vecs.push_back(make_vec("restore_freed",   0, 0, 0,    0, 0,    0, 0,    0, 0, 1, 0, 0, 7, 'h31, 1, 'h31, 1, 'h31, 1, 7, 1, 2));
        vecs.push_back(make_vec("restore_mid",     0, 0, 0,    0, 0,    0, 0,    0, 0, 1, 1, 0, 7, 'h30, 1, 'h31, 1, 'h30, 1, 7, 0, 2));

        reset_n = 1'b0;
        drive_idle();
        bus.rd_addr    = {5'd3, 5'd3};
        bus.lookup_tag = '0;
        #12;
        $display("[TB] checking outputs while reset is held");
        check_state("in_reset", 1'b0, 6'h00, 1'b0, 5'd0, 3'd0);
        check_output("in_reset.ckpt_id", 32'(bus.ckpt_id), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) apply_stimulus(vecs[i]);

        $display("[TB] reset asserted in the middle of a save");
        bus.ckpt_save  = 1'b1;
        bus.wr_en      = 2'b01;
        bus.wr_addr    = {5'd0, 5'd7};
        bus.wr_tag     = {6'h00, 6'h3c};
        bus.rd_addr    = {5'd7, 5'd7};
        bus.lookup_tag = 6'h30;
        #1;
        check_output("midsave.id_before", 32'(bus.ckpt_id), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_state("midsave.async", 1'b0, 6'h00, 1'b0, 5'd0, 3'd0);
        check_output("midsave.async_id", 32'(bus.ckpt_id), 32'd0);
        @(posedge clk);
        #1;
        check_state("midsave.held", 1'b0, 6'h00, 1'b0, 5'd0, 3'd0);
        reset_n     = 1'b1;
        bus.wr_en   = 2'b00;
        #1;
        check_output("first_save.id", 32'(bus.ckpt_id), 32'd0);
        @(posedge clk);
        #1;
        drive_idle();
        check_state("first_save.after", 1'b0, 6'h00, 1'b0, 5'd0, 3'd1);
        check_output("first_save.next_id", 32'(bus.ckpt_id), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rst_table.md
RST_TABLE -- requirements
Module: rst_table

Interface
REQ-001 Parameters SHALL be: NUM_REGS 32, number of architectural registers; TAG_W 6, tag width; NUM_RD 2, read ports; NUM_WR 2, write ports; NUM_CKPT 4, checkpoint slots.
REQ-002 Derived AW = clog2(NUM_REGS) and CW = clog2(NUM_CKPT) SHALL be used for address and checkpoint-id widths.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 rd_addr  in  NUM_RD*AW; rd_valid  out  NUM_RD; rd_tag  out  NUM_RD*TAG_W  read ports.
REQ-006 wr_addr  in  NUM_WR*AW; wr_tag  in  NUM_WR*TAG_W; wr_en  in  NUM_WR  dispatch rename writes.
REQ-007 cdb_valid  in  1; cdb_tag  in  TAG_W  result broadcast that clears matching pending entries.
REQ-008 lookup_tag  in  TAG_W; lookup_found  out  1; lookup_addr  out  AW  reverse tag search.
REQ-009 ckpt_save  in  1; ckpt_id  out  CW  id of the slot a save uses this cycle.
REQ-010 ckpt_restore  in  1; restore_id  in  CW; ckpt_release  in  1  recover and free the oldest checkpoint.
REQ-011 flush  in  1  synchronous full clear.
REQ-012 ckpt_full  out  1; ckpt_empty  out  1; ckpt_count  out  CW+1  checkpoint occupancy.

Function
REQ-013 Each entry SHALL hold {valid, tag}; valid=1 means the register awaits that tag.
REQ-014 Reads, lookup and status outputs SHALL be combinational from registered state only; there is no same-cycle write bypass.
REQ-015 Writes SHALL update the entry to {1, wr_tag} on the next edge; on equal addresses the higher-index port wins.
REQ-016 A CDB broadcast SHALL clear valid in every entry with valid=1 and tag==cdb_tag, unless a write targets that entry in the same cycle, in which case the write wins.
REQ-017 Lookup SHALL consider only valid entries; on multiple matches, the highest index is reported; otherwise the outputs are found=0 and addr=0.
REQ-018 The checkpoints SHALL form a circular FIFO with head and tail pointers (wrap at NUM_CKPT) and a count.
REQ-019 ckpt_save with count<NUM_CKPT SHALL store the post-update table (writes and CDB of the same cycle applied) into slot tail, drive ckpt_id=tail in that cycle, and advance tail.
REQ-020 ckpt_save while full SHALL be ignored; state is unchanged.
REQ-021 ckpt_release with count>0 SHALL advance head; a release while empty SHALL be ignored.
REQ-022 A simultaneous save and release SHALL both take effect, including when full; count is then unchanged.
REQ-023 ckpt_restore with restore_id inside [head, tail) SHALL load the table from that slot, discard that slot and all younger slots (tail=restore_id), and ignore writes, saves and releases in that cycle.
REQ-024 During a restore, a same-cycle CDB broadcast SHALL still clear matching entries of the restored table.
REQ-025 ckpt_restore with an id not currently allocated SHALL be ignored entirely.
REQ-026 flush SHALL have the highest priority: all valid bits clear, head=tail=count=0, and all other requests in that cycle are ignored.
REQ-027 Snapshot slots SHALL keep their stale contents when freed; only the pointers change.

Reset
REQ-028 reset_n low SHALL immediately clear all valid bits, tags, head, tail and count.
REQ-029 While in reset, outputs SHALL be: rd_valid=0, rd_tag=0, lookup_found=0, lookup_addr=0, ckpt_empty=1, ckpt_full=0, ckpt_count=0, ckpt_id=0.
REQ-030 Reset asserted mid-operation SHALL abandon any pending save or restore without partial update.
REQ-031 Snapshot storage SHALL need no reset.

Structure
REQ-032 Package rst_pkg SHALL hold the default constants for NUM_REGS, TAG_W, NUM_CKPT, and entry-width and clog2 helpers.
REQ-033 Sub-module rst_ckpt_fifo SHALL own the snapshot storage, head, tail, count and the id-range check; the top level owns the live table, ports, CDB logic and lookup.

Verification
REQ-034 Write r3 tag 0x11 on port 0 and r3 tag 0x22 on port 1 in the same cycle -> the next cycle reads {1,0x22}; a same-cycle read returns the old value.
REQ-035 With r5={1,0x07}, write r5 tag 0x09 and CDB 0x07 together -> r5={1,0x09}; with no write, CDB 0x07 -> r5 valid=0, lookup_found=0.
REQ-036 Perform 4 saves -> ids 0,1,2,3, ckpt_full=1; a 5th save is ignored; a save and release together -> count stays 4 and the id wraps to 0.
REQ-037 Set r1={1,0x01}, save (id 0), write r1 tag 0x02, save (id 1), then restore id 0 with CDB 0x01 -> r1 valid=0, count=0, ckpt_empty=1.
REQ-038 Restore an id outside [head, tail) -> no change; flush with a simultaneous write -> all valid=0, count=0, and the write is lost.
REQ-039 Assert reset_n low mid-save -> immediate clear; the first save after release gets ckpt_id=0.
